alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle integer ALU in the execute stage.
- Adds the following to the existing add/sub/and/or and beq/blt compare:
  - shifts
  - signed set-less-than
  - signed branch compare
  - iterative multi-cycle multiply
  - status flags
- Accepts one operation per valid/ready handshake and holds its registered result until the pipeline consumes it, so the execute stage can stall on multiply.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4, power of two).
- MUL_EN, 1, 1 = opcode MUL implemented; 0 = MUL treated as illegal.
- SHAMT_W, $clog2(WIDTH), derived localparam (not overridable): shift-amount bits taken from ip_1[SHAMT_W-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation present on ip_0/ip_1/opcode.
- in_ready  out  1  block can accept an operation this cycle.
- ip_0  in  WIDTH  operand A.
- ip_1  in  WIDTH  operand B / shift amount.
- opcode  in  4  operation select (encoding below).
- out_valid  out  1  op_0/change_pc/flags hold a completed result.
- out_ready  in  1  downstream consumes the result this cycle.
- op_0  out  WIDTH  result.
- change_pc  out  1  branch taken.
- zero  out  1  op_0 == 0.
- ovf  out  1  signed overflow (ADD/SUB only, else 0).
- illegal  out  1  opcode unsupported.

Behaviour:
- Opcode encoding (compatible with the previous ALU; the package enum, see Decomposition, carries the same values):
  - 0 NOP
  - 1 reserved
  - 2 BEQ
  - 3 BLTU (unsigned, as before)
  - 4 ADD
  - 5 SUB
  - 6 AND
  - 7 OR
  - 8 SLL
  - 9 SRL
  - 10 SRA
  - 11 SLT (signed; op_0 = 1/0)
  - 12 MUL (low WIDTH bits of the product)
  - 13 BLT (signed)
  - 14-15 reserved
- Result rules:
  - Branch opcodes: op_0 = 0, change_pc = comparison result.
  - All other opcodes: change_pc = 0.
  - NOP: op_0 = 0, illegal = 0.
  - 1, 14, 15, and MUL when MUL_EN = 0: op_0 = 0, change_pc = 0, illegal = 1.
- Arithmetic: all ops are modulo 2^WIDTH. ovf is set when the operand signs match (ADD) or differ (SUB) and the result sign differs from ip_0.
- Shifts: only ip_1[SHAMT_W-1:0] is used; upper bits are ignored.
- Reset (async, rst_n = 0):
  - state = IDLE
  - out_valid = 0, op_0 = 0, change_pc = 0, zero = 0, ovf = 0, illegal = 0
  - multiply registers = 0
  - in_ready = 0 while rst_n is low.
- A reset mid-multiply aborts the operation; no result is produced.
- Handshake:
  - Accept fires when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready), combinational.
  - A result is consumed when out_valid && out_ready.
  - Outputs are stable while out_valid && !out_ready.
- States: IDLE, MUL.
  - IDLE, accept, non-MUL opcode: the result is registered at the same edge; out_valid = 1 the next cycle (latency 1).
  - IDLE, accept, MUL: latch multiplicand/multiplier, clear accumulator, counter = 0, go to MUL.
  - MUL, each cycle: if multiplier bit 0 is set, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
  - MUL exit: after WIDTH iterations, register the accumulator to op_0, set out_valid = 1, return to IDLE.
  - MUL latency: accept edge + WIDTH cycles, so out_valid rises WIDTH+1 cycles after accept.
  - MUL flags: ovf = 0, zero computed from the product.
- Back-to-back: consuming a result and accepting a new operation in the same cycle is allowed. out_valid stays 1 and the new result replaces the old one at that edge.
- Consume without accept: out_valid falls to 0 and op_0 holds its value (don't-care).
- in_valid while in_ready = 0: the operation is not taken; the source must hold it.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (4-bit, values above)
  - OPC_W = 4
  - function is_branch(op)
  - function is_legal(op, mul_en)
- Sub-module alu_seq_mul: iterative shift-add multiplier.
  - Parameter: WIDTH.
  - Ports: clk, rst_n, start, a, b, done, product.
  - Owns the counter and shift registers.
  - alu_seq owns the FSM, handshake, and the combinational single-cycle datapath.

Test Plan:
- Reset: rst_n = 0 mid-MUL at cycle 5 -> out_valid = 0, op_0 = 0, in_ready = 0 during reset; in_ready = 1 the first cycle after release; no stale product appears.
- Single-cycle ops at WIDTH = 32, out_ready = 1:
  - ADD 0x7FFFFFFF + 1 -> op_0 = 0x80000000, ovf = 1, out_valid one cycle after accept.
  - SUB 5 - 5 -> zero = 1.
  - SRA 0x80000000 by ip_1 = 0x21 (shamt 1) -> 0xC0000000.
- Branch: BEQ 7,7 -> change_pc = 1, op_0 = 0. BLTU 0xFFFFFFFF,1 -> 0. BLT 0xFFFFFFFF,1 -> 1. SLT 0xFFFFFFFF,1 -> op_0 = 1.
- Multiply: MUL 0x0001_0003 x 0x0000_0005 -> op_0 = 0x0005_000F, out_valid exactly 33 cycles after accept, in_ready = 0 throughout. MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
- Backpressure: out_ready = 0 for 4 cycles after ADD 2+3 -> op_0 = 5 held stable, in_ready = 0. Raise out_ready with a new AND 0xF0 & 0x3C pending -> consume and accept in the same cycle; next op_0 = 0x30, out_valid stays 1.
- Illegal: opcodes 1, 14, 15, and 12 with MUL_EN = 0 -> illegal = 1, op_0 = 0, change_pc = 0, latency 1. NOP -> illegal = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcode encoding, FSM states and decode helpers for alu_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 4'd0,
    OP_RSV1  = 4'd1,
    OP_BEQ   = 4'd2,
    OP_BLTU  = 4'd3,
    OP_ADD   = 4'd4,
    OP_SUB   = 4'd5,
    OP_AND   = 4'd6,
    OP_OR    = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_SRA   = 4'd10,
    OP_SLT   = 4'd11,
    OP_MUL   = 4'd12,
    OP_BLT   = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  function automatic logic is_branch(input alu_op_e op);
    return (op == OP_BEQ) || (op == OP_BLTU) || (op == OP_BLT);
  endfunction

  function automatic logic is_legal(input alu_op_e op, input logic mul_en);
    logic legal;
    case (op)
      OP_RSV1, OP_RSV14, OP_RSV15: legal = 1'b0;
      OP_MUL:                      legal = mul_en;
      default:                     legal = 1'b1;
    endcase
    return legal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_mul.sv
// ============================================================================
// Module : alu_seq_mul
// Brief  : Iterative shift-add multiplier, one partial product per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             last_iter;

  assign last_iter = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_iter) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // The final partial product is forwarded so the caller can register it on
  // the same edge as the last iteration.
  assign done    = last_iter;
  assign product = acc_d;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module : alu_seq
// Brief  : Handshaked execute-stage ALU with single-cycle ops and iterative MUL.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ip_0,
  input  logic [WIDTH-1:0] ip_1,
  input  logic [OPC_W-1:0] opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op_0,
  output logic             change_pc,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] op_0_q, op_0_d;
  logic             change_pc_q, change_pc_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;

  alu_op_e          op;
  logic             accept;
  logic             mul_op;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH-1:0]   res;
  logic               res_cpc, res_ovf, res_ill;

  assign op       = alu_op_e'(opcode);
  assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_op   = (op == OP_MUL) && (MUL_EN != 0);

  assign shamt = ip_1[SHAMT_W-1:0];
  assign sum   = ip_0 + ip_1;
  assign diff  = ip_0 - ip_1;

  always_comb begin
    res     = '0;
    res_cpc = 1'b0;
    res_ovf = 1'b0;
    res_ill = !is_legal(op, MUL_EN != 0);
    case (op)
      OP_BEQ:  res_cpc = (ip_0 == ip_1);
      OP_BLTU: res_cpc = (ip_0 < ip_1);
      OP_BLT:  res_cpc = ($signed(ip_0) < $signed(ip_1));
      OP_ADD: begin
        res     = sum;
        res_ovf = (ip_0[WIDTH-1] == ip_1[WIDTH-1]) && (sum[WIDTH-1] != ip_0[WIDTH-1]);
      end
      OP_SUB: begin
        res     = diff;
        res_ovf = (ip_0[WIDTH-1] != ip_1[WIDTH-1]) && (diff[WIDTH-1] != ip_0[WIDTH-1]);
      end
      OP_AND:  res = ip_0 & ip_1;
      OP_OR:   res = ip_0 | ip_1;
      OP_SLL:  res = ip_0 << shamt;
      OP_SRL:  res = ip_0 >> shamt;
      OP_SRA:  res = $signed(ip_0) >>> shamt;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(ip_0) < $signed(ip_1))};
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    op_0_d      = op_0_q;
    change_pc_d = change_pc_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    mul_start   = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (mul_op) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            out_valid_d = 1'b1;
            op_0_d      = res;
            change_pc_d = res_cpc;
            zero_d      = (res == '0);
            ovf_d       = res_ovf;
            illegal_d   = res_ill;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          out_valid_d = 1'b1;
          op_0_d      = mul_product;
          change_pc_d = 1'b0;
          zero_d      = (mul_product == '0);
          ovf_d       = 1'b0;
          illegal_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      op_0_q      <= '0;
      change_pc_q <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      op_0_q      <= op_0_d;
      change_pc_q <= change_pc_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
    end
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_seq_mul #(
        .WIDTH(WIDTH)
      ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (ip_0),
        .b       (ip_1),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      logic unused_mul_start;
      assign unused_mul_start = mul_start;
      assign mul_done         = 1'b0;
      assign mul_product      = '0;
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign op_0      = op_0_q;
  assign change_pc = change_pc_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module : tb_alu_seq
// Brief  : Scoreboard bench for alu_seq against an arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

  localparam int W   = 32;
  localparam int LAT_MUL = W + 1;

  typedef struct {
    logic [W-1:0] op0;
    logic         cpc;
    logic         zero;
    logic         ovf;
    logic         ill;
    logic         is_mul;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] ip_0 = '0;
  logic [W-1:0] ip_1 = '0;
  logic [3:0]   opcode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] op_0;
  logic         change_pc, zero, ovf, illegal;

  logic         d0_in_valid = 1'b0;
  logic         d0_in_ready;
  logic [W-1:0] d0_ip_0 = '0;
  logic [W-1:0] d0_ip_1 = '0;
  logic [3:0]   d0_opcode = '0;
  logic         d0_out_valid;
  logic         d0_out_ready = 1'b1;
  logic [W-1:0] d0_op_0;
  logic         d0_change_pc, d0_zero, d0_ovf, d0_illegal;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb[$];
  bit   seen = 0;
  bit   mul_busy = 0;
  bit   ready_rand = 0;
  bit   ready_force = 1;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .MUL_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ip_0(ip_0), .ip_1(ip_1), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .op_0(op_0), .change_pc(change_pc), .zero(zero),
    .ovf(ovf), .illegal(illegal)
  );

  alu_seq #(.WIDTH(W), .MUL_EN(0)) u_dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .ip_0(d0_ip_0), .ip_1(d0_ip_1), .opcode(d0_opcode), .out_valid(d0_out_valid),
    .out_ready(d0_out_ready), .op_0(d0_op_0), .change_pc(d0_change_pc), .zero(d0_zero),
    .ovf(d0_ovf), .illegal(d0_illegal)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: results from signed/unsigned integer arithmetic on wide values.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit mul_en);
    exp_t   e;
    longint sa, sbv, full;
    logic [63:0] prod;
    int     amt;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    amt = int'(b % W);
    e.op0 = '0; e.cpc = 0; e.ovf = 0; e.ill = 0; e.is_mul = 0; e.cyc = 0;
    case (op)
      4'd0:  ;
      4'd2:  e.cpc = (a == b);
      4'd3:  e.cpc = (a < b);
      4'd4:  begin full = sa + sbv; e.op0 = W'(full);
                   e.ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      4'd5:  begin full = sa - sbv; e.op0 = W'(full);
                   e.ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      4'd6:  e.op0 = a & b;
      4'd7:  e.op0 = a | b;
      4'd8:  e.op0 = a << amt;
      4'd9:  e.op0 = a >> amt;
      4'd10: e.op0 = W'(sa >>> amt);
      4'd11: e.op0 = (sa < sbv) ? 1 : 0;
      4'd12: if (mul_en) begin prod = 64'(a) * 64'(b); e.op0 = prod[W-1:0]; e.is_mul = 1; end
             else e.ill = 1;
      4'd13: e.cpc = (sa < sbv);
      default: e.ill = 1;
    endcase
    e.zero = (e.op0 == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: compares the head of the scoreboard whenever a result is presented.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      seen = 0;
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_op_0", op_0, '0);
      chk("rst_in_ready", W'(in_ready), W'(0));
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_out_valid: got op_0 %h with no pending op (cycle %0d)", op_0, cyc);
        end else begin
          e = sb[0];
          if (!seen) begin
            seen = 1;
            chk("latency_cycle", W'(cyc), W'(e.cyc));
            if (e.is_mul) mul_busy = 0;
          end
          chk("op_0", op_0, e.op0);
          chk("change_pc", W'(change_pc), W'(e.cpc));
          chk("zero", W'(zero), W'(e.zero));
          chk("ovf", W'(ovf), W'(e.ovf));
          chk("illegal", W'(illegal), W'(e.ill));
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end
      chk("in_ready", W'(in_ready), W'(!mul_busy && (!out_valid || out_ready)));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   waited = 0;
    bit   done = 0;
    in_valid = 1; opcode = op; ip_0 = a; ip_1 = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(op, a, b, 1);
        e.cyc = cyc + (e.is_mul ? LAT_MUL : 1);
        sb.push_back(e);
        done = 1;
      end else if (++waited > 300) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected 1", waited);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (e.is_mul && waited <= 300) mul_busy = 1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
      mul_busy = 0;
    end
  endtask

  task automatic issue_nomul(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   waited = 0;
    e = model(op, a, b, 0);
    d0_in_valid = 1; d0_opcode = op; d0_ip_0 = a; d0_ip_1 = b;
    @(negedge clk);
    while (!d0_in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    d0_in_valid = 0;
    @(negedge clk);
    chk("nomul_out_valid", W'(d0_out_valid), W'(1));
    chk("nomul_op_0", d0_op_0, e.op0);
    chk("nomul_change_pc", W'(d0_change_pc), W'(e.cpc));
    chk("nomul_illegal", W'(d0_illegal), W'(e.ill));
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    issue(4'd4, 32'h7FFF_FFFF, 32'h1);
    issue(4'd5, 32'd5, 32'd5);
    issue(4'd10, 32'h8000_0000, 32'h21);
    issue(4'd2, 32'd7, 32'd7);
    issue(4'd3, 32'hFFFF_FFFF, 32'd1);
    issue(4'd13, 32'hFFFF_FFFF, 32'd1);
    issue(4'd11, 32'hFFFF_FFFF, 32'd1);
    issue(4'd12, 32'h0001_0003, 32'h0000_0005);
    issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'd1, 32'd9, 32'd3);
    issue(4'd14, 32'd9, 32'd3);
    issue(4'd15, 32'd9, 32'd3);
    issue(4'd0, 32'd3, 32'd4);
    drain();

    ready_force = 0;
    issue(4'd4, 32'd2, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    fork
      issue(4'd6, 32'hF0, 32'h3C);
      begin
        repeat (2) @(posedge clk);
        ready_force = 1;
      end
    join
    drain();

    issue(4'd12, 32'h1234_5678, 32'h0000_0101);
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    sb.delete();
    mul_busy = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (40) @(posedge clk);
    #1;

    ready_rand = 1;
    for (int i = 0; i < 200; i++) begin
      issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
    end
    ready_rand = 0;
    ready_force = 1;
    repeat (3) @(posedge clk);
    #1;
    drain();

    issue_nomul(4'd12, 32'd6, 32'd7);
    issue_nomul(4'd4, 32'd1, 32'd2);
    issue_nomul(4'd14, 32'd1, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
